// File: rtl/dispatch_if.sv
// Bundle of signals between dispatch_ctrl and its neighbours: IFetch, Decoder,
// the ROB/RS/LSB release strobes, the rollback flush and the occupancy counts.
interface dispatch_if #(
  parameter int CW = 5
);
  logic          IF_success;
  logic [31:0]   instr;
  logic [31:0]   fetch_pc;
  logic          if_stall;
  logic          dec_valid;
  logic [31:0]   dec_instr;
  logic [31:0]   dec_pc;
  logic          rob_commit;
  logic          rs_release;
  logic          lsb_release;
  logic          rollback;
  logic [CW-1:0] rob_count;
  logic [CW-1:0] rs_count;
  logic [CW-1:0] lsb_count;

  modport master (
    input  IF_success, instr, fetch_pc, rob_commit, rs_release, lsb_release, rollback,
    output if_stall, dec_valid, dec_instr, dec_pc, rob_count, rs_count, lsb_count
  );

  modport slave (
    output IF_success, instr, fetch_pc, rob_commit, rs_release, lsb_release, rollback,
    input  if_stall, dec_valid, dec_instr, dec_pc, rob_count, rs_count, lsb_count
  );
endinterface

// File: rtl/dispatch_ctrl.sv
// Issue sequencer between IFetch and Decoder: credit-tracks ROB/RS/LSB occupancy,
// parks one blocked instruction in a hold register and flushes on rollback.
module dispatch_ctrl #(
  parameter int ROB_SIZE = 16,
  parameter int RS_SIZE  = 16,
  parameter int LSB_SIZE = 16,
  parameter int CW       = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rdy,
  dispatch_if.master bus
);

  typedef enum logic [1:0] {S_RUN, S_HOLD, S_FLUSH} state_e;
  typedef enum logic [1:0] {CLS_NONE, CLS_RS, CLS_LSB} cls_e;

  localparam logic [CW-1:0] ROB_MAX = CW'(ROB_SIZE);
  localparam logic [CW-1:0] RS_MAX  = CW'(RS_SIZE);
  localparam logic [CW-1:0] LSB_MAX = CW'(LSB_SIZE);

  state_e      state;
  logic        hold_vld;
  logic [31:0] hold_instr;
  logic [31:0] hold_pc;

  logic        cand_vld;
  logic [31:0] cand_instr;
  logic [31:0] cand_pc;
  cls_e        cand_cls;
  logic        cand_ok;
  logic        fwd;
  logic        park;

  function automatic cls_e classify(input logic [6:0] op);
    case (op)
      7'b0000011, 7'b0100011:                          classify = CLS_LSB;
      7'b0010011, 7'b0010111, 7'b0110011, 7'b0110111,
      7'b1100011, 7'b1100111, 7'b1101111:              classify = CLS_RS;
      default:                                         classify = CLS_NONE;
    endcase
  endfunction

  // A release against an empty counter is ignored; forward and release cancel out.
  function automatic logic [CW-1:0] next_count(input logic [CW-1:0] cnt,
                                               input logic inc, input logic dec);
    logic dec_eff;
    dec_eff = dec && (cnt != '0);
    if (inc && !dec_eff)      next_count = cnt + 1'b1;
    else if (dec_eff && !inc) next_count = cnt - 1'b1;
    else                      next_count = cnt;
  endfunction

  always_comb begin
    cand_vld   = 1'b0;
    cand_instr = bus.instr;
    cand_pc    = bus.fetch_pc;
    case (state)
      S_RUN: cand_vld = bus.IF_success;
      S_HOLD: begin
        cand_vld   = hold_vld;
        cand_instr = hold_instr;
        cand_pc    = hold_pc;
      end
      default: cand_vld = 1'b0;
    endcase

    cand_cls = classify(cand_instr[6:0]);
    case (cand_cls)
      CLS_RS:  cand_ok = (bus.rob_count < ROB_MAX) && (bus.rs_count  < RS_MAX);
      CLS_LSB: cand_ok = (bus.rob_count < ROB_MAX) && (bus.lsb_count < LSB_MAX);
      default: cand_ok = 1'b0;
    endcase

    fwd  = cand_vld && cand_ok;
    park = (state == S_RUN) && cand_vld && (cand_cls != CLS_NONE) && !cand_ok;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_RUN;
      bus.dec_valid <= 1'b0;
      bus.if_stall  <= 1'b0;
      bus.dec_instr <= '0;
      bus.dec_pc    <= '0;
      bus.rob_count <= '0;
      bus.rs_count  <= '0;
      bus.lsb_count <= '0;
      hold_vld      <= 1'b0;
      hold_instr    <= '0;
      hold_pc       <= '0;
    end else if (rdy) begin
      if (bus.rollback) begin
        state         <= S_FLUSH;
        bus.dec_valid <= 1'b0;
        bus.if_stall  <= 1'b0;
        bus.rob_count <= '0;
        bus.rs_count  <= '0;
        bus.lsb_count <= '0;
        hold_vld      <= 1'b0;
      end else begin
        bus.rob_count <= next_count(bus.rob_count, fwd, bus.rob_commit);
        bus.rs_count  <= next_count(bus.rs_count,  fwd && (cand_cls == CLS_RS),  bus.rs_release);
        bus.lsb_count <= next_count(bus.lsb_count, fwd && (cand_cls == CLS_LSB), bus.lsb_release);
        bus.dec_valid <= fwd;
        if (fwd) begin
          bus.dec_instr <= cand_instr;
          bus.dec_pc    <= cand_pc;
        end
        case (state)
          S_RUN: begin
            if (park) begin
              hold_vld     <= 1'b1;
              hold_instr   <= bus.instr;
              hold_pc      <= bus.fetch_pc;
              bus.if_stall <= 1'b1;
              state        <= S_HOLD;
            end
          end
          S_HOLD: begin
            if (fwd) begin
              hold_vld     <= 1'b0;
              bus.if_stall <= 1'b0;
              state        <= S_RUN;
            end
          end
          default: state <= S_RUN;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dispatch_ctrl.sv
// Directed bench for dispatch_ctrl: expected forwards are queued at issue time and
// a negedge monitor pops them whenever the Decoder would consume dec_valid.
module tb_dispatch_ctrl;
  localparam int CW = 5;
  localparam logic [31:0] ADDI = 32'h00100093;
  localparam logic [31:0] LW   = 32'h00002083;
  localparam logic [31:0] ADD  = 32'h002081b3;
  localparam logic [31:0] BAD  = 32'h0000007f;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic rdy;
  int   total = 0;
  int   bad   = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  dispatch_if #(.CW(CW)) dif();

  dispatch_ctrl #(
    .ROB_SIZE(16), .RS_SIZE(16), .LSB_SIZE(16), .CW(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rdy(rdy),
    .bus(dif)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic chk_state(input string name, input logic dv, input logic stall,
                           input int rob, input int rs, input int lsb);
    check({name, ".dec_valid"}, 32'(dif.dec_valid), 32'(dv));
    check({name, ".if_stall"},  32'(dif.if_stall),  32'(stall));
    check({name, ".rob_count"}, 32'(dif.rob_count), 32'(rob));
    check({name, ".rs_count"},  32'(dif.rs_count),  32'(rs));
    check({name, ".lsb_count"}, 32'(dif.lsb_count), 32'(lsb));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] ins, input logic [31:0] pc, input bit expect_fwd);
    dif.IF_success = 1'b1;
    dif.instr      = ins;
    dif.fetch_pc   = pc;
    if (expect_fwd) exp_q.push_back('{ins, pc});
  endtask

  task automatic idle();
    dif.IF_success = 1'b0;
  endtask

  // Decoder consumes dec_valid at the next posedge only when rdy is high there.
  always @(negedge clk) begin
    if (dif.dec_valid === 1'b1 && rdy === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_fwd: got instr %h pc %h want none", dif.dec_instr, dif.dec_pc);
      end else begin
        mon_e = exp_q.pop_front();
        check("fwd_instr", dif.dec_instr, mon_e.instr);
        check("fwd_pc",    dif.dec_pc,    mon_e.pc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    dif.IF_success  = 1'b0;
    dif.instr       = '0;
    dif.fetch_pc    = '0;
    dif.rob_commit  = 1'b0;
    dif.rs_release  = 1'b0;
    dif.lsb_release = 1'b0;
    dif.rollback    = 1'b0;
    rdy = 1'b1;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk_state("reset", 1'b0, 1'b0, 0, 0, 0);
    check("reset.dec_instr", dif.dec_instr, 32'h0);
    check("reset.dec_pc",    dif.dec_pc,    32'h0);

    // ADDI forwarded with one-cycle latency
    drive(ADDI, 32'h1000, 1'b1);
    step();
    idle();
    chk_state("t1_addi", 1'b1, 1'b0, 1, 1, 0);
    check("t1_addi.dec_instr", dif.dec_instr, ADDI);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_state("t1_rereset", 1'b0, 1'b0, 0, 0, 0);

    // fill LSB (and ROB) with 16 loads, then block the 17th
    for (int i = 0; i < 16; i++) begin
      drive(LW, 32'h2000 + 32'(4 * i), 1'b1);
      step();
    end
    idle();
    chk_state("t2_16lw", 1'b1, 1'b0, 16, 0, 16);
    drive(LW, 32'h2040, 1'b1);
    step();
    idle();
    chk_state("t2_stall", 1'b0, 1'b1, 16, 0, 16);
    step();
    chk_state("t2_held", 1'b0, 1'b1, 16, 0, 16);
    dif.rob_commit  = 1'b1;
    dif.lsb_release = 1'b1;
    step();
    dif.rob_commit  = 1'b0;
    dif.lsb_release = 1'b0;
    chk_state("t2_release", 1'b0, 1'b1, 15, 0, 15);
    step();
    chk_state("t2_unblock", 1'b1, 1'b0, 16, 0, 16);
    check("t2_unblock.dec_pc", dif.dec_pc, 32'h2040);

    // rollback while holding with a full ROB
    drive(LW, 32'h2044, 1'b0);
    step();
    idle();
    chk_state("t4_hold", 1'b0, 1'b1, 16, 0, 16);
    dif.rollback    = 1'b1;
    dif.rob_commit  = 1'b1;
    dif.lsb_release = 1'b1;
    step();
    dif.rollback    = 1'b0;
    dif.rob_commit  = 1'b0;
    dif.lsb_release = 1'b0;
    chk_state("t4_rollback", 1'b0, 1'b0, 0, 0, 0);
    drive(ADDI, 32'h3000, 1'b0);
    step();
    idle();
    chk_state("t4_flush_drop", 1'b0, 1'b0, 0, 0, 0);
    drive(ADDI, 32'h3004, 1'b1);
    step();
    idle();
    chk_state("t4_after_flush", 1'b1, 1'b0, 1, 1, 0);

    // forward and release on RS in the same cycle
    drive(ADDI, 32'h3008, 1'b1);
    step();
    drive(ADDI, 32'h300c, 1'b1);
    step();
    idle();
    chk_state("t3_rs3", 1'b1, 1'b0, 3, 3, 0);
    drive(ADD, 32'h3010, 1'b1);
    dif.rs_release = 1'b1;
    step();
    idle();
    dif.rs_release = 1'b0;
    chk_state("t3_fwd_release", 1'b1, 1'b0, 4, 3, 0);

    // unknown opcode is dropped
    drive(BAD, 32'h3014, 1'b0);
    step();
    idle();
    chk_state("t5_drop", 1'b0, 1'b0, 4, 3, 0);

    // rdy low freezes everything, including dec_valid and pending commits
    drive(ADDI, 32'h3018, 1'b1);
    step();
    idle();
    chk_state("t6_fwd", 1'b1, 1'b0, 5, 4, 0);
    rdy = 1'b0;
    dif.rob_commit = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_state("t6_frozen", 1'b1, 1'b0, 5, 4, 0);
      check("t6_frozen.dec_instr", dif.dec_instr, ADDI);
      check("t6_frozen.dec_pc",    dif.dec_pc,    32'h3018);
    end
    dif.rob_commit = 1'b0;
    rdy = 1'b1;
    step();
    chk_state("t6_resume", 1'b0, 1'b0, 5, 4, 0);
    step();

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL pending_fwd: got %0d outstanding want 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
